// File: rtl/xvc_driver_operation.sv
// xvc_driver_operation: start/done driver for Clause-22 MDIO transfers and PHY hardware reset.
// Optional macro SGMII_LOOPBACK_EN loops the SGMII RX pair straight back onto the TX pair.
module xvc_driver_operation #(
    parameter int MDC_DIV    = 20,
    parameter int RST_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    output logic        done_port,
    output logic [31:0] return_port,
    input  logic [7:0]  operation,
    input  logic [31:0] address,
    input  logic [31:0] value,
    output logic        sgmii_tx_p,
    output logic        sgmii_tx_n,
    input  logic        sgmii_rx_p,
    input  logic        sgmii_rx_n,
    input  logic        sgmii_clk_p,
    input  logic        sgmii_clk_n,
    input  logic        eth_mdio_i,
    output logic        eth_mdio_o,
    output logic        eth_mdio_t,
    output logic        eth_mdc,
    output logic        eth_reset_n
);

    typedef enum logic [1:0] {IDLE, MDIO_SHIFT, PHY_RST, DONE} state_t;

    localparam int DIV_W = $clog2(MDC_DIV);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    state_t             state, state_d;
    logic [7:0]         op_q, op_d;
    logic [63:0]        frame_q, frame_d;
    logic [DIV_W-1:0]   div_cnt, div_cnt_d;
    logic [6:0]         half_cnt, half_cnt_d;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_d;
    logic [15:0]        rd_data, rd_data_d;
    logic               done_d, mdc_d, mdio_o_d, mdio_t_d, reset_n_d;
    logic [31:0]        return_d;

    logic        div_tick, mdc_rise, mdc_fall, frame_end, rst_end, is_read, is_write;
    logic [63:0] new_frame;
    logic [6:0]  next_bit;

    assign is_read   = (op_q == 8'd0);
    assign is_write  = (operation == 8'd1);
    assign div_tick  = (div_cnt == DIV_W'(MDC_DIV - 1));
    assign mdc_rise  = (state == MDIO_SHIFT) && div_tick && !half_cnt[0];
    assign mdc_fall  = (state == MDIO_SHIFT) && div_tick && half_cnt[0];
    assign frame_end = mdc_fall && (half_cnt == 7'd127);
    assign rst_end   = (state == PHY_RST) && (rst_cnt == RST_W'(RST_CYCLES - 1));
    assign next_bit  = {1'b0, half_cnt[6:1]} + 7'd1;

    // Reads leave TA and data as 1s; the pad is released for those bits anyway.
    assign new_frame = {32'hFFFF_FFFF, 2'b01,
                        is_write ? 2'b01 : 2'b10,
                        address[9:5], address[4:0],
                        is_write ? {2'b10, value[15:0]} : 18'h3_FFFF};

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start_port) begin
                    case (operation)
                        8'd0, 8'd1: state_d = MDIO_SHIFT;
                        8'd2:       state_d = PHY_RST;
                        default:    state_d = DONE;
                    endcase
                end
            end
            MDIO_SHIFT: if (frame_end) state_d = DONE;
            PHY_RST:    if (rst_end)   state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        frame_d    = frame_q;
        div_cnt_d  = div_cnt;
        half_cnt_d = half_cnt;
        rst_cnt_d  = rst_cnt;
        rd_data_d  = rd_data;
        done_d     = 1'b0;
        return_d   = return_port;
        mdc_d      = eth_mdc;
        mdio_o_d   = eth_mdio_o;
        mdio_t_d   = eth_mdio_t;
        reset_n_d  = 1'b1;
        case (state)
            IDLE: begin
                if (start_port) begin
                    op_d = operation;
                    if (operation == 8'd0 || operation == 8'd1) begin
                        frame_d    = new_frame;
                        div_cnt_d  = '0;
                        half_cnt_d = '0;
                        rd_data_d  = '0;
                        mdc_d      = 1'b0;
                        mdio_o_d   = new_frame[63];
                        mdio_t_d   = 1'b0;
                    end else if (operation == 8'd2) begin
                        rst_cnt_d = '0;
                        reset_n_d = 1'b0;
                    end
                end
            end
            MDIO_SHIFT: begin
                if (div_tick) begin
                    div_cnt_d  = '0;
                    half_cnt_d = half_cnt + 7'd1;
                    mdc_d      = !eth_mdc;
                    if (mdc_rise && is_read && half_cnt[6:1] >= 6'd48)
                        rd_data_d = {rd_data[14:0], eth_mdio_i};
                    if (frame_end) begin
                        mdio_o_d = 1'b1;
                        mdio_t_d = 1'b1;
                    end else if (mdc_fall) begin
                        frame_d  = {frame_q[62:0], 1'b1};
                        mdio_o_d = frame_q[62];
                        mdio_t_d = is_read && (next_bit >= 7'd46);
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            PHY_RST: begin
                reset_n_d = rst_end;
                if (!rst_end) rst_cnt_d = rst_cnt + RST_W'(1);
            end
            DONE: begin
                done_d = 1'b1;
                case (op_q)
                    8'd0:       return_d = {16'h0000, rd_data};
                    8'd1, 8'd2: return_d = 32'h0000_0000;
                    default:    return_d = 32'hFFFF_FFFF;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q        <= '0;
            frame_q     <= '1;
            div_cnt     <= '0;
            half_cnt    <= '0;
            rst_cnt     <= '0;
            rd_data     <= '0;
            done_port   <= 1'b0;
            return_port <= '0;
            eth_mdc     <= 1'b0;
            eth_mdio_o  <= 1'b1;
            eth_mdio_t  <= 1'b1;
            eth_reset_n <= 1'b0;
        end else begin
            op_q        <= op_d;
            frame_q     <= frame_d;
            div_cnt     <= div_cnt_d;
            half_cnt    <= half_cnt_d;
            rst_cnt     <= rst_cnt_d;
            rd_data     <= rd_data_d;
            done_port   <= done_d;
            return_port <= return_d;
            eth_mdc     <= mdc_d;
            eth_mdio_o  <= mdio_o_d;
            eth_mdio_t  <= mdio_t_d;
            eth_reset_n <= reset_n_d;
        end
    end

`ifdef SGMII_LOOPBACK_EN
    assign sgmii_tx_p = sgmii_rx_p;
    assign sgmii_tx_n = sgmii_rx_n;
    logic unused_inputs;
    assign unused_inputs = ^{sgmii_clk_p, sgmii_clk_n, address[31:10], value[31:16], frame_q[63]};
`else
    assign sgmii_tx_p = 1'b0;
    assign sgmii_tx_n = 1'b1;
    logic unused_inputs;
    assign unused_inputs = ^{sgmii_rx_p, sgmii_rx_n, sgmii_clk_p, sgmii_clk_n,
                             address[31:10], value[31:16], frame_q[63]};
`endif

endmodule

// File: tb/tb_xvc_driver_operation.sv
// Self-checking bench for xvc_driver_operation: a cycle-indexed behavioural model
// predicts every output from the frame layout and operation timing rules.
module tb_xvc_driver_operation;

    localparam int D         = 2;
    localparam int R         = 10;
    localparam int MDIO_DONE = 128 * D + 2;
    localparam int RST_DONE  = R + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_port = 1'b0;
    logic        done_port;
    logic [31:0] return_port;
    logic [7:0]  operation = '0;
    logic [31:0] address = '0;
    logic [31:0] value = '0;
    logic        sgmii_tx_p, sgmii_tx_n;
    logic        sgmii_rx_p = 1'b0, sgmii_rx_n = 1'b1;
    logic        sgmii_clk_p = 1'b0, sgmii_clk_n = 1'b1;
    logic        eth_mdio_i = 1'b1;
    logic        eth_mdio_o, eth_mdio_t, eth_mdc, eth_reset_n;

    always #5 clock = ~clock;

    xvc_driver_operation #(.MDC_DIV(D), .RST_CYCLES(R)) dut (
        .clock(clock), .reset(reset), .start_port(start_port), .done_port(done_port),
        .return_port(return_port), .operation(operation), .address(address), .value(value),
        .sgmii_tx_p(sgmii_tx_p), .sgmii_tx_n(sgmii_tx_n), .sgmii_rx_p(sgmii_rx_p),
        .sgmii_rx_n(sgmii_rx_n), .sgmii_clk_p(sgmii_clk_p), .sgmii_clk_n(sgmii_clk_n),
        .eth_mdio_i(eth_mdio_i), .eth_mdio_o(eth_mdio_o), .eth_mdio_t(eth_mdio_t),
        .eth_mdc(eth_mdc), .eth_reset_n(eth_reset_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_c is the index of the current cycle after the start edge (1 = first).
    bit          m_valid = 0, m_in_reset = 1, m_active = 0;
    int          m_c = 0, m_n = 0;
    logic [7:0]  m_op = '0;
    logic [63:0] m_frame = '1;
    logic [15:0] m_rd = '0, rd_plan = '0;
    logic [31:0] m_ret = '0, m_result = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_valid = 1; m_in_reset = 1; m_active = 0; m_ret = '0;
        end else begin
            m_in_reset = 0;
            if (m_active && m_c < m_n) begin
                m_c++;
                if (m_c == m_n) m_ret = m_result;
            end else if (start_port) begin
                m_active = 1; m_c = 1; m_op = operation; m_rd = rd_plan;
                m_frame = {32'hFFFF_FFFF, 2'b01, (operation == 8'd1) ? 2'b01 : 2'b10,
                           address[9:5], address[4:0],
                           (operation == 8'd1) ? {2'b10, value[15:0]} : 18'h3_FFFF};
                case (operation)
                    8'd0:    begin m_n = MDIO_DONE; m_result = {16'h0000, rd_plan}; end
                    8'd1:    begin m_n = MDIO_DONE; m_result = 32'h0; end
                    8'd2:    begin m_n = RST_DONE;  m_result = 32'h0; end
                    default: begin m_n = 2;         m_result = 32'hFFFF_FFFF; end
                endcase
            end else begin
                m_active = 0;
            end
        end
    end

    // Compare process: every output, every cycle, at the falling edge.
    always @(negedge clock) begin
        logic e_done, e_mdc, e_o, e_t, e_rn;
        int   b;
        if (m_valid) begin
            e_done = 0; e_mdc = 0; e_o = 1; e_t = 1; e_rn = !m_in_reset;
            if (m_active) begin
                if (m_op <= 8'd1 && m_c <= 128 * D) begin
                    b     = (m_c - 1) / (2 * D);
                    e_mdc = (((m_c - 1) / D) % 2) == 1;
                    e_t   = (m_op == 8'd0) && (b >= 46);
                    e_o   = m_frame[63 - b];
                end
                if (m_op == 8'd2 && m_c <= R) e_rn = 0;
                if (m_c == m_n) e_done = 1;
            end
            check("done_port", 64'(done_port), 64'(e_done));
            check("return_port", 64'(return_port), 64'(m_ret));
            check("eth_mdc", 64'(eth_mdc), 64'(e_mdc));
            check("eth_mdio_t", 64'(eth_mdio_t), 64'(e_t));
            if (!e_t) check("eth_mdio_o", 64'(eth_mdio_o), 64'(e_o));
            check("eth_reset_n", 64'(eth_reset_n), 64'(e_rn));
            check("sgmii_tx", 64'({sgmii_tx_p, sgmii_tx_n}), 64'(2'b01));
        end
    end

    // PHY side: drive read data during the data bits, noise elsewhere.
    always @(negedge clock) begin
        if (m_active && m_op == 8'd0 && m_c <= 128 * D && (m_c - 1) / (2 * D) >= 48)
            eth_mdio_i = m_rd[63 - (m_c - 1) / (2 * D)];
        else
            eth_mdio_i = 1'($urandom_range(0, 1));
    end

    logic [63:0] cap = '0;
    int cap_n = 0, done_cnt = 0, rn_low = 0;

    always @(posedge eth_mdc) begin
        cap = {cap[62:0], eth_mdio_o};
        cap_n++;
    end
    always @(negedge clock) begin
        if (done_port === 1'b1) done_cnt++;
        if (reset && eth_reset_n === 1'b0) rn_low++;
    end

    task automatic do_start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] v,
                            input logic [15:0] rd);
        @(negedge clock);
        rd_plan = rd; operation = op; address = a; value = v; start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        operation = 8'($urandom); address = $urandom; value = $urandom;
    endtask

    // Returns the cycle index (1 = first cycle after the start edge) in which done was seen.
    task automatic wait_done(input int max_cycles, output int cyc);
        cyc = 1;
        while (done_port !== 1'b1 && cyc <= max_cycles) begin
            @(negedge clock);
            cyc++;
        end
        check("done_within_budget", 64'(done_port === 1'b1), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, d0, r;
        logic [7:0] op;

        // Reset held for two edges, released between edges.
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_reset_n_low", 64'(eth_reset_n), 64'(0));
        check("rst_outputs", 64'({done_port, eth_mdc, eth_mdio_o, eth_mdio_t}), 64'(4'b0011));
        check("rst_return", 64'(return_port), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        check("rst_reset_n_release", 64'(eth_reset_n), 64'(1));
        repeat (3) @(negedge clock);
        check("rst_no_done", 64'(done_cnt), 64'(0));

        // Write PHY 1 reg 5 = 0x1234.
        cap_n = 0;
        do_start(8'd1, 32'h025, 32'h1234, 16'h0);
        wait_done(400, cyc);
        check("write_latency", 64'(cyc), 64'(258));
        check("write_return", 64'(return_port), 64'(0));
        check("write_frame", cap, 64'hFFFF_FFFF_5096_1234);
        check("write_mdc_rises", 64'(cap_n), 64'(64));

        // Read PHY 1 reg 1, PHY returns 0xBEEF.
        cap_n = 0;
        do_start(8'd0, 32'h021, 32'h0, 16'hBEEF);
        wait_done(400, cyc);
        check("read_latency", 64'(cyc), 64'(258));
        check("read_return", 64'(return_port), 64'h0000_BEEF);
        @(negedge clock);
        check("read_done_one_cycle", 64'(done_port), 64'(0));

        // Illegal opcode.
        cap_n = 0;
        do_start(8'd7, 32'h0, 32'h0, 16'h0);
        wait_done(10, cyc);
        check("illegal_latency", 64'(cyc), 64'(2));
        check("illegal_return", 64'(return_port), 64'hFFFF_FFFF);
        check("illegal_no_mdc", 64'(cap_n), 64'(0));

        // PHY reset.
        rn_low = 0;
        do_start(8'd2, 32'h0, 32'h0, 16'h0);
        wait_done(40, cyc);
        check("phyrst_latency", 64'(cyc), 64'(RST_DONE));
        check("phyrst_low_cycles", 64'(rn_low), 64'(10));
        check("phyrst_return", 64'(return_port), 64'(0));

        // A second start during a frame is ignored.
        repeat (2) @(negedge clock);
        d0 = done_cnt; cap_n = 0;
        do_start(8'd1, 32'h025, 32'h1234, 16'h0);
        repeat (50) @(negedge clock);
        do_start(8'd0, 32'h3FF, 32'hFFFF, 16'h5555);
        wait_done(400, cyc);
        repeat (10) @(negedge clock);
        check("busy_start_single_done", 64'(done_cnt - d0), 64'(1));
        check("busy_start_frame", cap, 64'hFFFF_FFFF_5096_1234);
        check("busy_start_return", 64'(return_port), 64'(0));

        // Reset in the middle of a frame aborts without a done.
        d0 = done_cnt;
        do_start(8'd0, 32'h0AB, 32'h0, 16'hA5A5);
        repeat (100) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_mdc_low", 64'(eth_mdc), 64'(0));
        check("abort_mdio_released", 64'(eth_mdio_t), 64'(1));
        reset = 1'b1;
        repeat (300) @(negedge clock);
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));

        // Randomized operations; the compare process checks every cycle.
        for (int i = 0; i < 12; i++) begin
            r  = int'($urandom_range(0, 3));
            op = (r < 3) ? 8'(r) : 8'($urandom_range(3, 255));
            d0 = done_cnt;
            do_start(op, $urandom, $urandom, 16'($urandom));
            wait_done(400, cyc);
            repeat (int'($urandom_range(1, 4))) @(negedge clock);
            check("random_single_done", 64'(done_cnt - d0), 64'(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xvc_driver_operation.md
Name: xvc_driver_operation

Overview:
Command-driven PHY management driver for the XVC microserver Ethernet path. It accepts one operation per start pulse and executes it on the Clause-22 MDIO bus or on the PHY hardware reset line. It reports a result on a start/done/return handshake. The SGMII serial pins are owned here: TX is held idle and RX/clock inputs are received but not decoded by this block.

Parameters:
MDC_DIV, 20, clock cycles per MDC half-period (MDC frequency = f_clock / (2*MDC_DIV)); minimum 2.
RST_CYCLES, 1000, clock cycles eth_reset_n is held low by the PHY-reset operation.

Ports:
clock  in  1  system clock; every register updates on the rising edge.
reset  in  1  synchronous, active-low reset.
start_port  in  1  one-cycle request strobe.
done_port  out  1  one-cycle completion strobe.
return_port  out  32  operation result.
operation  in  8  opcode: 0 = MDIO read, 1 = MDIO write, 2 = PHY reset, others = illegal.
address  in  32  [9:5] = PHY address, [4:0] = register address; [31:10] ignored.
value  in  32  write data in [15:0]; [31:16] ignored.
sgmii_tx_p, sgmii_tx_n  out  1 each  SGMII transmit pair.
sgmii_rx_p, sgmii_rx_n  in  1 each  SGMII receive pair (unused unless loopback).
sgmii_clk_p, sgmii_clk_n  in  1 each  SGMII reference clock (unused).
eth_mdio_i  in  1  MDIO pad input.
eth_mdio_o  out  1  MDIO pad output value.
eth_mdio_t  out  1  MDIO tristate control: 1 = release (input), 0 = drive eth_mdio_o.
eth_mdc  out  1  MDIO clock.
eth_reset_n  out  1  PHY hardware reset, active-low.

Behaviour:
- Reset (reset=0 at a clock edge) produces these outputs:
  - done_port=0, return_port=0, eth_mdc=0, eth_mdio_o=1, eth_mdio_t=1.
  - eth_reset_n=0, sgmii_tx_p=0, sgmii_tx_n=1.
  - FSM goes to IDLE.
  - eth_reset_n rises to 1 on the first edge with reset=1.
  - Reset mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, MDIO_SHIFT, PHY_RST, DONE.
- IDLE, on start_port=1:
  - operation, address and value are latched.
  - op 0/1 → MDIO_SHIFT; op 2 → PHY_RST; other → DONE with return 0xFFFF_FFFF.
- start_port is ignored outside IDLE. Input changes after the latch edge have no effect.
- MDIO_SHIFT: a 64-bit frame is built from:
  - 32 preamble 1s;
  - ST = 01;
  - OP = 10 for read, 01 for write;
  - PHYAD[4:0], then REGAD[4:0], MSB first;
  - TA, then 16 data bits, MSB first.
  - For writes, TA = 10 and the data bits are value[15:0].
- MDC generation:
  - eth_mdc toggles every MDC_DIV cycles, starting low.
  - Each frame bit is presented on eth_mdio_o at the MDC falling transition (the first bit at entry), so it is stable across the rising edge.
- eth_mdio_t is 0 while driving. For reads, eth_mdio_t=1 from the first TA bit through the end of the frame.
- Read data: eth_mdio_i is sampled in the clock cycle where eth_mdc goes 0→1, during the 16 data bits, and shifted in MSB first.
- Frame end: after the 64th MDC rising half and its high half-period, eth_mdc=0, eth_mdio_t=1, eth_mdio_o=1, then → DONE.
- Total MDIO latency: done_port asserts exactly 128*MDC_DIV+2 cycles after the start edge.
- PHY_RST: eth_reset_n=0 for exactly RST_CYCLES cycles, then 1, then → DONE. Return value is 0.
- DONE:
  - done_port=1 for exactly one cycle, with return_port valid in the same cycle.
  - Read returns {16'h0, data}; write and PHY reset return 0.
  - return_port holds until the next completion.
  - → IDLE; a new start is accepted on the following cycle.

Optional Feature:
SGMII_LOOPBACK_EN:
- Defined: sgmii_tx_p = sgmii_rx_p and sgmii_tx_n = sgmii_rx_n, combinationally, for link bring-up testing. Reset does not affect this path.
- Undefined: TX is constant idle, p=0 and n=1.

Test Plan:
- Reset held low 2 cycles then released → all outputs at reset values; eth_reset_n=1 one cycle after release; done_port never pulses.
- MDC_DIV=2, start op=1, address=0x025 (PHY 1, reg 5), value=0x1234 → eth_mdio_o at successive MDC rises = 32×1, 0101, 00001, 00101, 10, 0001001000110100; eth_mdio_t=0 throughout; done after 258 cycles; return=0.
- MDC_DIV=2, op=0, address=0x021, bench drives 0xBEEF on eth_mdio_i during the data phase → eth_mdio_t=1 from TA onward; return_port=0x0000BEEF with a one-cycle done.
- op=7 → done 2 cycles after start, return=0xFFFFFFFF, no MDC activity.
- op=2, RST_CYCLES=10 → eth_reset_n low exactly 10 cycles; done follows; return=0.
- Second start pulse during an MDIO frame → ignored: single done, frame unaltered. Reset asserted mid-frame → MDC stops low, eth_mdio_t=1, no done.
